// File: rtl/alu_req_arbiter_if.sv
// Requester/response handshake bundle for alu_req_arbiter.
// master = requesters and response consumer, slave = arbiter.
interface alu_req_arbiter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned RW = 16
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [CW-1:0] req0_cmd;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [CW-1:0] req1_cmd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [RW-1:0] rsp_data;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    output req1_valid, req1_a, req1_b, req1_cmd,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latches the winner's operands, holds them for ALU_LAT cycles, returns the captured result.
module alu_req_arbiter #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned RW      = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_req_arbiter_if.slave bus,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [CW-1:0] alu_cmd_o,
  output logic          alu_oe_o,
  input  logic [RW-1:0] alu_d_out_i,
  output logic          busy_o,
  output logic [15:0]   op_count_o
);
  localparam int unsigned LW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          oe_q, oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [RW-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]   op_count_q, op_count_d;
  logic          grant0, grant1;

  // rr_q = 0 favours requester 0 when both are valid.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_q);

  assign bus.req0_ready = (state_q == StIdle) & grant0;
  assign bus.req1_ready = (state_q == StIdle) & grant1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_cmd_o      = cmd_q;
  assign alu_oe_o       = oe_q;
  assign busy_o         = (state_q != StIdle);
  assign op_count_o     = op_count_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lat_d       = lat_q;
    a_d         = a_q;
    b_d         = b_q;
    cmd_d       = cmd_q;
    oe_d        = oe_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          a_d      = grant1 ? bus.req1_a   : bus.req0_a;
          b_d      = grant1 ? bus.req1_b   : bus.req0_b;
          cmd_d    = grant1 ? bus.req1_cmd : bus.req0_cmd;
          rsp_id_d = grant1;
          rr_d     = ~grant1;
          lat_d    = LW'(ALU_LAT);
          oe_d     = 1'b1;
          state_d  = StExec;
        end
      end
      StExec: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LW'(1)) begin
          rsp_data_d  = alu_d_out_i;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      lat_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lat_q       <= lat_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cmd_q       <= cmd_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
    end
  end
endmodule
